// File: rtl/mux4_arb_pkg.sv
// Shared types and sizes for the four-way round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first unmasked request after last_ptr, wrapping,
// so last_ptr itself is the lowest-priority candidate.
module rr_picker
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] last_ptr,
  output logic             found,
  output logic [SEL_W-1:0] winner
);

  logic [N_REQ-1:0] eligible;

  assign eligible = req & ~mask;

  always_comb begin
    found  = 1'b0;
    winner = last_ptr;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      if (!found && eligible[last_ptr + SEL_W'(k)]) begin
        found  = 1'b1;
        winner = last_ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared mux4 path, with bounded
// grant hold and back-to-back handover between requesters.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SEL_W-1:0] last_ptr, last_nxt;

  logic             owner_gone;
  logic             expire;
  logic             release_now;
  logic [N_REQ-1:0] pick_mask;
  logic [SEL_W-1:0] pick_ptr;
  logic             found;
  logic [SEL_W-1:0] winner;

  // Owner is excluded from the next pick only when it dropped or finished;
  // pure expiry leaves it eligible so a lone requester is re-granted.
  assign owner_gone  = !req[sel] || done;
  assign expire      = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign release_now = owner_gone || expire;
  assign pick_mask   = (state == GRANT && owner_gone) ? (N_REQ'(1) << sel) : '0;
  assign pick_ptr    = (state == GRANT) ? sel : last_ptr;

  rr_picker u_picker (
    .req      (req),
    .mask     (pick_mask),
    .last_ptr (pick_ptr),
    .found    (found),
    .winner   (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
      last_ptr <= SEL_W'(N_REQ - 1);
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      hold_cnt <= cnt_nxt;
      last_ptr <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    busy_nxt  = busy;
    cnt_nxt   = hold_cnt;
    last_nxt  = last_ptr;

    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          gnt_nxt   = N_REQ'(1) << winner;
          sel_nxt   = winner;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!release_now) begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end else begin
          last_nxt = sel;
          cnt_nxt  = '0;
          if (found) begin
            gnt_nxt = N_REQ'(1) << winner;
            sel_nxt = winner;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic             done;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             busy;
  logic [CNT_W-1:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner index (-1 when idle), hold count, last owner.
  int m_own, m_sel, m_cnt, m_last;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    int         cnt;
  } vec_t;

  vec_t tbl[13];

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_sel = 0; m_cnt = 0; m_last = 3;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int win;
    bit gone;
    if (m_own < 0) begin
      win = rr_pick(r, m_last, -1);
      if (win >= 0) begin
        m_own = win; m_sel = win; m_cnt = 0;
      end
    end else begin
      gone = !r[m_own] || d;
      if (!gone && m_cnt != int'(MAX_HOLD) - 1) begin
        m_cnt++;
      end else begin
        m_last = m_own;
        win = rr_pick(r, m_last, gone ? m_own : -1);
        m_cnt = 0;
        if (win >= 0) begin
          m_own = win; m_sel = win;
        end else begin
          m_own = -1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".gnt"},  int'(gnt),      (m_own < 0) ? 0 : (1 << m_own));
    check({tag, ".sel"},  int'(sel),      m_sel);
    check({tag, ".busy"}, int'(busy),     (m_own < 0) ? 0 : 1);
    check({tag, ".cnt"},  int'(hold_cnt), (m_own < 0) ? 0 : m_cnt);
  endtask

  task automatic step(input logic [3:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;
    model_reset();

    tbl[0]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 0};
    tbl[1]  = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1};
    tbl[2]  = '{4'b0110, 1'b0, 4'b0010, 2'd1, 2};
    tbl[3]  = '{4'b0110, 1'b1, 4'b0100, 2'd2, 0};
    tbl[4]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1};
    tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 2'd2, 0};
    tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 2'd2, 0};
    tbl[7]  = '{4'b0101, 1'b0, 4'b0001, 2'd0, 0};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0100, 2'd2, 0};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 0};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 0};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 0};
    tbl[12] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 0};

    // Reset state
    do_reset();
    check("rst.gnt", int'(gnt), 0);
    check("rst.sel", int'(sel), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.cnt", int'(hold_cnt), 0);

    // Directed table: handover on done, drop to idle, RR resume, done while idle
    for (int i = 0; i < 13; i++) begin
      req  = tbl[i].req;
      done = tbl[i].done;
      @(posedge clk);
      model_step(tbl[i].req, tbl[i].done);
      #1;
      check($sformatf("tbl%0d.gnt", i), int'(gnt), int'(tbl[i].gnt));
      check($sformatf("tbl%0d.sel", i), int'(sel), int'(tbl[i].sel));
      check($sformatf("tbl%0d.busy", i), int'(busy), (tbl[i].gnt != 0) ? 1 : 0);
      check($sformatf("tbl%0d.cnt", i), int'(hold_cnt), tbl[i].cnt);
    end

    // Lone requester re-granted every MAX_HOLD cycles
    do_reset();
    for (int i = 0; i < 3 * int'(MAX_HOLD); i++) begin
      step(4'b0001, 1'b0, "solo");
      check("solo.cnt_seq", int'(hold_cnt), i % int'(MAX_HOLD));
      check("solo.gnt_seq", int'(gnt), 1);
    end

    // All requesting: 0,1,2,3,0 each for exactly MAX_HOLD cycles
    do_reset();
    for (int i = 0; i < 5 * int'(MAX_HOLD); i++) begin
      step(4'b1111, 1'b0, "all");
      check("all.owner", int'(gnt), 1 << ((i / int'(MAX_HOLD)) % 4));
      check("all.busy_seq", int'(busy), 1);
    end

    // Async reset mid-grant, between clock edges
    do_reset();
    step(4'b0100, 1'b0, "ar0");
    step(4'b0100, 1'b0, "ar1");
    #2 rst = 1'b1;
    #1;
    check("async.gnt", int'(gnt), 0);
    check("async.sel", int'(sel), 0);
    check("async.busy", int'(busy), 0);
    check("async.cnt", int'(hold_cnt), 0);
    #1 rst = 1'b0;
    model_reset();
    step(4'b1000, 1'b0, "ar2");
    check("async.regrant", int'(gnt), 4'b1000);

    // Owner 3 at expiry: done+expiry, plain expiry, lone-owner re-grant
    for (int pass = 0; pass < 3; pass++) begin
      do_reset();
      step(4'b1000, 1'b0, "exp_own");
      for (int i = 1; i < int'(MAX_HOLD) - 1; i++) step(4'b1001, 1'b0, "exp_hold");
      check("exp.pre_cnt", int'(hold_cnt), int'(MAX_HOLD) - 2);
      step(4'b1001, 1'b0, "exp_last");
      check("exp.at_cnt", int'(hold_cnt), int'(MAX_HOLD) - 1);
      if (pass == 0) step(4'b1001, 1'b1, "exp_done");
      else if (pass == 1) step(4'b1001, 1'b0, "exp_rr");
      else step(4'b1000, 1'b0, "exp_solo");
      check($sformatf("exp%0d.gnt", pass), int'(gnt), (pass == 2) ? 4'b1000 : 4'b0001);
      check($sformatf("exp%0d.cnt", pass), int'(hold_cnt), 0);
    end

    // Randomized traffic against the model
    do_reset();
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        step(r, ($urandom_range(0, 7) == 0), "rand");
        if (gnt != 0) check("rand.onehot", int'(gnt), 1 << int'(sel));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
